// File: rtl/cap_pkg.sv
// cap_pkg: shared types and constants for the capture write-DMA path.
//   cap_state_e      - DMA sequencer states
//   axi_ctl_t        - registered AXI handshake controls driven by the sequencer
//   SIZE_4B / BURST_INCR / RESP_OKAY - fixed AXI encodings
//   BURSTS_PER_FRAME / BYTES_PER_BURST - derived from the default geometry;
//   the helper functions derive the same values for any parameterisation.
package cap_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_VS = 3'd1,
        FILL    = 3'd2,
        ADDR    = 3'd3,
        DATA    = 3'd4,
        RESP    = 3'd5
    } cap_state_e;

    typedef struct packed {
        logic awvalid;
        logic wvalid;
        logic wlast;
        logic bready;
    } axi_ctl_t;

    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    localparam int H_SIZE_DEF    = 640;
    localparam int V_SIZE_DEF    = 480;
    localparam int BURST_LEN_DEF = 16;

    localparam int BURSTS_PER_FRAME = H_SIZE_DEF * V_SIZE_DEF / BURST_LEN_DEF;
    localparam int BYTES_PER_BURST  = BURST_LEN_DEF * 4;

    function automatic int bursts_per_frame(input int h, input int v, input int bl);
        return h * v / bl;
    endfunction

    function automatic int bytes_per_burst(input int bl);
        return bl * 4;
    endfunction

endpackage

// File: rtl/cap_vsync_det.sv
// cap_vsync_det: brings raw VSYNC into the ACLK domain and flags its falling edge.
//   ACLK     in  system clock
//   ARESETN  in  synchronous reset, active low
//   VSYNC    in  raw vertical sync from the pixel domain
//   vs_fall  out one-cycle falling-edge strobe (2-3 cycles after the raw edge)
module cap_vsync_det (
    input  logic ACLK,
    input  logic ARESETN,
    input  logic VSYNC,
    output logic vs_fall
);

    // sync[0] is the metastability catcher; sync[2] doubles as edge history.
    logic [2:0] sync;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) sync <= '0;
        else          sync <= {sync[1:0], VSYNC};
    end

    assign vs_fall = sync[2] & ~sync[1];

endmodule

// File: rtl/cap_dmactrl.sv
// cap_dmactrl: write-DMA sequencer moving one captured frame from the FWFT
// capture FIFO to memory as fixed-length AXI4 INCR bursts, started by a
// VSYNC falling edge while CAPON is set.
//   ACLK/ARESETN           clock, synchronous active-low reset
//   VSYNC, CAPON, CAPADDR  frame trigger, enable, base byte address
//   FIFO_CNT/DOUT/RE/CLR   capture FIFO fill level, head word, pop, flush
//   AW*/W*/B*              AXI4 write master (AW and W strictly sequential)
//   DMA_BUSY               high outside IDLE/WAIT_VS
//   FRAME_END, RESP_ERR    one-cycle status pulses
module cap_dmactrl
    import cap_pkg::*;
#(
    parameter int H_SIZE     = 640,
    parameter int V_SIZE     = 480,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_CNT_W = 10
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  VSYNC,
    input  logic                  CAPON,
    input  logic [28:0]           CAPADDR,
    input  logic [FIFO_CNT_W-1:0] FIFO_CNT,
    input  logic [31:0]           FIFO_DOUT,
    output logic                  FIFO_RE,
    output logic                  FIFO_CLR,
    output logic [31:0]           AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic [1:0]            AWBURST,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [31:0]           WDATA,
    output logic [3:0]            WSTRB,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic                  DMA_BUSY,
    output logic                  FRAME_END,
    output logic                  RESP_ERR
);

    localparam int BPF    = bursts_per_frame(H_SIZE, V_SIZE, BURST_LEN);
    localparam int BPB    = bytes_per_burst(BURST_LEN);
    localparam int IDX_W  = (BPF > 1) ? $clog2(BPF) : 1;
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(BPF - 1);
    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [FIFO_CNT_W-1:0] FILL_LVL  = FIFO_CNT_W'(BURST_LEN);

    cap_state_e        state;
    axi_ctl_t          ctl;
    logic [31:0]       base;
    logic [31:0]       awaddr_q;
    logic [IDX_W-1:0]  burst_idx;
    logic [BEAT_W-1:0] beat;
    logic              fifo_clr_q;
    logic              frame_end_q;
    logic              resp_err_q;
    logic              busy_q;
    logic              vs_fall;

    // Base is forced to 64-byte alignment, so the low address bits are unused.
    logic unused_capaddr_lo;
    assign unused_capaddr_lo = ^CAPADDR[5:0];

    cap_vsync_det u_vsync_det (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .VSYNC   (VSYNC),
        .vs_fall (vs_fall)
    );

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state       <= IDLE;
            ctl         <= '0;
            base        <= '0;
            awaddr_q    <= '0;
            burst_idx   <= '0;
            beat        <= '0;
            fifo_clr_q  <= 1'b0;
            frame_end_q <= 1'b0;
            resp_err_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fifo_clr_q  <= 1'b0;
            frame_end_q <= 1'b0;
            resp_err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (CAPON) state <= WAIT_VS;
                end
                WAIT_VS: begin
                    if (!CAPON) begin
                        state <= IDLE;
                    end else if (vs_fall) begin
                        base       <= {3'b000, CAPADDR[28:6], 6'b0};
                        burst_idx  <= '0;
                        beat       <= '0;
                        fifo_clr_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    // FIFO_CNT is stale during the flush cycle, so ignore it then.
                    if (!CAPON) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (!fifo_clr_q && FIFO_CNT >= FILL_LVL) begin
                        ctl.awvalid <= 1'b1;
                        awaddr_q    <= base + (32'(burst_idx) * 32'(BPB));
                        state       <= ADDR;
                    end
                end
                ADDR: begin
                    if (AWREADY) begin
                        ctl.awvalid <= 1'b0;
                        ctl.wvalid  <= 1'b1;
                        ctl.wlast   <= (LAST_BEAT == '0);
                        state       <= DATA;
                    end
                end
                DATA: begin
                    if (WREADY) begin
                        if (beat == LAST_BEAT) begin
                            beat       <= '0;
                            ctl.wvalid <= 1'b0;
                            ctl.wlast  <= 1'b0;
                            ctl.bready <= 1'b1;
                            state      <= RESP;
                        end else begin
                            beat      <= beat + BEAT_W'(1);
                            ctl.wlast <= ((beat + BEAT_W'(1)) == LAST_BEAT);
                        end
                    end
                end
                RESP: begin
                    if (BVALID) begin
                        ctl.bready <= 1'b0;
                        resp_err_q <= (BRESP != RESP_OKAY);
                        burst_idx  <= burst_idx + IDX_W'(1);
                        if (burst_idx == LAST_IDX) begin
                            frame_end_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state       <= WAIT_VS;
                        end else if (!CAPON) begin
                            // Frame abandoned after the in-flight burst drains.
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                default: begin
                    ctl    <= '0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // FWFT head is stable until popped, so WDATA holds across a W stall.
    assign FIFO_RE   = ctl.wvalid & WREADY;
    assign FIFO_CLR  = fifo_clr_q;
    assign WDATA     = ctl.wvalid ? FIFO_DOUT : 32'h0;
    assign AWADDR    = awaddr_q;
    assign AWVALID   = ctl.awvalid;
    assign WVALID    = ctl.wvalid;
    assign WLAST     = ctl.wlast;
    assign BREADY    = ctl.bready;
    assign DMA_BUSY  = busy_q;
    assign FRAME_END = frame_end_q;
    assign RESP_ERR  = resp_err_q;

    assign AWLEN   = 8'(BURST_LEN - 1);
    assign AWSIZE  = SIZE_4B;
    assign AWBURST = BURST_INCR;
    assign WSTRB   = 4'hF;

endmodule

// File: tb/tb_cap_dmactrl.sv
module tb_cap_dmactrl;
    import cap_pkg::*;

    localparam int H  = 32;
    localparam int V  = 2;
    localparam int BL = 16;
    localparam int CW = 10;
    localparam logic [31:0] DBASE = 32'hD000_0000;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic          VSYNC = 1'b0;
    logic          CAPON = 1'b0;
    logic [28:0]   CAPADDR = '0;
    logic [CW-1:0] FIFO_CNT = '0;
    logic [31:0]   FIFO_DOUT;
    logic          FIFO_RE, FIFO_CLR;
    logic [31:0]   AWADDR;
    logic [7:0]    AWLEN;
    logic [2:0]    AWSIZE;
    logic [1:0]    AWBURST;
    logic          AWVALID;
    logic          AWREADY = 1'b1;
    logic [31:0]   WDATA;
    logic [3:0]    WSTRB;
    logic          WLAST, WVALID;
    logic          WREADY = 1'b1;
    logic [1:0]    BRESP;
    logic          BVALID = 1'b1;
    logic          BREADY, DMA_BUSY, FRAME_END, RESP_ERR;

    int checks = 0;
    int errors = 0;

    // bench-side stimulus state
    int          aw_mode = 0, w_mode = 0, err_b_abs = -1;
    int          aw_wait = 0;
    logic [1:0]  wcyc = '0;
    logic [3:0]  wpat = 4'b1001;   // WREADY sequence 1,0,0,1
    logic [31:0] fifo_head = DBASE;

    // monitor results (cumulative; tests take snapshots)
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, re_cnt = 0, clr_cnt = 0;
    int fe_cnt = 0, err_cnt = 0, hold_viol = 0, aw_stall = 0, w_stall = 0;
    int aw_out = 0;
    logic        aw_stall_p = 0, w_stall_p = 0, wlast_p = 0;
    logic [31:0] awaddr_p = '0, wdata_p = '0;
    logic [31:0] aw_q[$];
    logic [31:0] wdata_q[$];
    int          wlast_q[$];
    int          fe_b_q[$];

    int aw0, w0, b0, re0, clr0, fe0, err0, hv0, aws0, ws0, wl0;

    cap_dmactrl #(.H_SIZE(H), .V_SIZE(V), .BURST_LEN(BL), .FIFO_CNT_W(CW)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .VSYNC(VSYNC), .CAPON(CAPON), .CAPADDR(CAPADDR),
        .FIFO_CNT(FIFO_CNT), .FIFO_DOUT(FIFO_DOUT), .FIFO_RE(FIFO_RE), .FIFO_CLR(FIFO_CLR),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY), .BRESP(BRESP),
        .BVALID(BVALID), .BREADY(BREADY), .DMA_BUSY(DMA_BUSY),
        .FRAME_END(FRAME_END), .RESP_ERR(RESP_ERR)
    );

    always #5 ACLK = ~ACLK;

    assign FIFO_DOUT = fifo_head;
    assign BRESP = (b_cnt == err_b_abs) ? 2'b10 : 2'b00;

    // ready generators
    always @(negedge ACLK) begin
        aw_wait <= AWVALID ? aw_wait + 1 : 0;
        AWREADY <= (aw_mode == 0) ? 1'b1 : (AWVALID && aw_wait >= 5);
        wcyc    <= wcyc + 2'd1;
        WREADY  <= (w_mode == 0) ? 1'b1 : wpat[wcyc];
    end

    // monitor
    always @(posedge ACLK) begin : mon
        int v;
        v = 0;
        if (FIFO_CLR)     fifo_head <= DBASE;
        else if (FIFO_RE) fifo_head <= fifo_head + 32'd1;
        if (!ARESETN) begin
            aw_out     <= 0;
            aw_stall_p <= 1'b0;
            w_stall_p  <= 1'b0;
        end else begin
            if (aw_stall_p && (!AWVALID || AWADDR != awaddr_p)) v++;
            if (w_stall_p && (!WVALID || WDATA != wdata_p || WLAST != wlast_p)) v++;
            if (WVALID && aw_out == 0) v++;
            if (WVALID && AWVALID) v++;
            hold_viol  <= hold_viol + v;
            aw_stall_p <= AWVALID && !AWREADY;
            w_stall_p  <= WVALID && !WREADY;
            awaddr_p   <= AWADDR;
            wdata_p    <= WDATA;
            wlast_p    <= WLAST;
            if (AWVALID && !AWREADY) aw_stall <= aw_stall + 1;
            if (WVALID && !WREADY)   w_stall  <= w_stall + 1;
            if (AWVALID && AWREADY) begin
                aw_cnt <= aw_cnt + 1;
                aw_q.push_back(AWADDR);
            end
            if (WVALID && WREADY) begin
                w_cnt <= w_cnt + 1;
                wdata_q.push_back(WDATA);
                if (WLAST) wlast_q.push_back(w_cnt);
            end
            aw_out <= aw_out + ((AWVALID && AWREADY) ? 1 : 0)
                             - ((WVALID && WREADY && WLAST) ? 1 : 0);
            if (FIFO_RE)  re_cnt  <= re_cnt + 1;
            if (FIFO_CLR) clr_cnt <= clr_cnt + 1;
            if (RESP_ERR) err_cnt <= err_cnt + 1;
            if (BVALID && BREADY) b_cnt <= b_cnt + 1;
            if (FRAME_END) begin
                fe_cnt <= fe_cnt + 1;
                fe_b_q.push_back(b_cnt);
            end
        end
    end

    task automatic snap();
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; re0 = re_cnt; clr0 = clr_cnt;
        fe0 = fe_cnt; err0 = err_cnt; hv0 = hold_viol; aws0 = aw_stall;
        ws0 = w_stall; wl0 = wlast_q.size();
    endtask

    function automatic int cur(input int sel);
        case (sel)
            0: return aw_cnt;
            1: return w_cnt;
            2: return fe_cnt;
            default: return DMA_BUSY ? 0 : 1;
        endcase
    endfunction

    // bounded wait; an expired budget counts as a failed comparison
    task automatic wait_on(input int sel, input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (cur(sel) < target && n < budget) begin
            @(negedge ACLK);
            n++;
        end
        checks++;
        if (cur(sel) < target) begin
            errors++;
            $display("FAIL %s timeout: got %0d required %0d", tag, cur(sel), target);
        end
    endtask

    task automatic vsync_pulse();
        @(negedge ACLK) VSYNC = 1'b1;
        repeat (3) @(negedge ACLK);
        VSYNC = 1'b0;
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        CAPON   = 1'b0;
        repeat (3) @(negedge ACLK);
        checks++;
        if ({AWVALID, WVALID, WLAST, BREADY, FIFO_RE, FIFO_CLR, FRAME_END, RESP_ERR, DMA_BUSY} !== 9'h0) begin
            errors++;
            $display("FAIL reset_ctl: got %b required 0", {AWVALID, WVALID, WLAST, BREADY, FIFO_RE, FIFO_CLR, FRAME_END, RESP_ERR, DMA_BUSY});
        end
        checks++;
        if ({AWADDR, WDATA} !== 64'h0) begin
            errors++;
            $display("FAIL reset_addr_data: got %h %h required 0", AWADDR, WDATA);
        end
        checks++;
        if ({AWLEN, AWSIZE, AWBURST, WSTRB} !== {8'd15, 3'b010, 2'b01, 4'hF}) begin
            errors++;
            $display("FAIL reset_consts: got %h %b %b %h required 0f 010 01 f", AWLEN, AWSIZE, AWBURST, WSTRB);
        end
        checks++;
        if (dut.state !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d required %0d", dut.state, IDLE);
        end
        ARESETN = 1'b1;
    endtask

    // shared expectations for a complete default frame
    logic [31:0] exp_addr[4];
    int          exp_last[4];

    task automatic check_frame(input string tag);
        checks++;
        if (aw_cnt - aw0 != 4) begin
            errors++;
            $display("FAIL %s_aw_count: got %0d required 4", tag, aw_cnt - aw0);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (aw_q[aw0 + i] !== exp_addr[i]) begin
                errors++;
                $display("FAIL %s_awaddr%0d: got %h required %h", tag, i, aw_q[aw0 + i], exp_addr[i]);
            end
            checks++;
            if (wlast_q[wl0 + i] - w0 != exp_last[i]) begin
                errors++;
                $display("FAIL %s_wlast%0d: got beat %0d required %0d", tag, i, wlast_q[wl0 + i] - w0, exp_last[i]);
            end
        end
        checks++;
        if (re_cnt - re0 != 64) begin
            errors++;
            $display("FAIL %s_pops: got %0d required 64", tag, re_cnt - re0);
        end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (wdata_q[w0 + i] !== DBASE + 32'(i)) begin
                errors++;
                $display("FAIL %s_wdata%0d: got %h required %h", tag, i, wdata_q[w0 + i], DBASE + 32'(i));
            end
        end
        checks++;
        if (hold_viol - hv0 != 0) begin
            errors++;
            $display("FAIL %s_stability: got %0d violations required 0", tag, hold_viol - hv0);
        end
        checks++;
        if (fe_cnt - fe0 != 1 || fe_b_q[fe0] - b0 != 4) begin
            errors++;
            $display("FAIL %s_frame_end: got %0d pulses after %0d resps required 1 after 4", tag, fe_cnt - fe0, fe_b_q[fe0] - b0);
        end
    endtask

    task automatic test_basic_frame();
        CAPADDR  = 29'h0100_0040;
        CAPON    = 1'b1;
        FIFO_CNT = 10'd512;
        repeat (2) @(negedge ACLK);
        snap();
        vsync_pulse();
        wait_on(2, fe0 + 1, 600, "basic_frame_end");
        repeat (2) @(negedge ACLK);
        check_frame("basic");
        checks++;
        if (clr_cnt - clr0 != 1) begin
            errors++;
            $display("FAIL basic_fifo_clr: got %0d required 1", clr_cnt - clr0);
        end
        checks++;
        if (DMA_BUSY !== 1'b0 || dut.state !== WAIT_VS) begin
            errors++;
            $display("FAIL basic_end_state: got busy %b state %0d required 0 %0d", DMA_BUSY, dut.state, WAIT_VS);
        end
    endtask

    task automatic test_backpressure();
        aw_mode = 1;
        w_mode  = 1;
        repeat (2) @(negedge ACLK);
        snap();
        vsync_pulse();
        wait_on(2, fe0 + 1, 1500, "bp_frame_end");
        repeat (2) @(negedge ACLK);
        check_frame("bp");
        checks++;
        if (aw_stall - aws0 != 20) begin
            errors++;
            $display("FAIL bp_aw_stall: got %0d cycles required 20", aw_stall - aws0);
        end
        checks++;
        if (w_stall - ws0 == 0) begin
            errors++;
            $display("FAIL bp_w_stall: got 0 cycles required nonzero");
        end
        aw_mode = 0;
        w_mode  = 0;
        repeat (2) @(negedge ACLK);
    endtask

    task automatic test_starvation();
        FIFO_CNT = 10'd15;
        snap();
        vsync_pulse();
        repeat (8) @(negedge ACLK);
        checks++;
        if (DMA_BUSY !== 1'b1 || dut.state !== FILL) begin
            errors++;
            $display("FAIL starve_fill: got busy %b state %0d required 1 %0d", DMA_BUSY, dut.state, FILL);
        end
        repeat (20) @(negedge ACLK);
        checks++;
        if (AWVALID !== 1'b0 || aw_cnt != aw0) begin
            errors++;
            $display("FAIL starve_no_aw: got awvalid %b bursts %0d required 0 0", AWVALID, aw_cnt - aw0);
        end
        FIFO_CNT = 10'd16;
        @(negedge ACLK);
        checks++;
        if (AWVALID !== 1'b1) begin
            errors++;
            $display("FAIL starve_release: got awvalid %b required 1", AWVALID);
        end
        wait_on(2, fe0 + 1, 600, "starve_frame_end");
        checks++;
        if (aw_cnt - aw0 != 4) begin
            errors++;
            $display("FAIL starve_bursts: got %0d required 4", aw_cnt - aw0);
        end
        FIFO_CNT = 10'd512;
        repeat (2) @(negedge ACLK);
    endtask

    task automatic test_capon_drop();
        snap();
        vsync_pulse();
        wait_on(1, w0 + 21, 300, "drop_reach_beat5");
        CAPON = 1'b0;
        wait_on(3, 1, 200, "drop_idle");
        repeat (10) @(negedge ACLK);
        checks++;
        if (aw_cnt - aw0 != 2 || re_cnt - re0 != 32 || b_cnt - b0 != 2) begin
            errors++;
            $display("FAIL drop_drain: got aw %0d pops %0d resp %0d required 2 32 2", aw_cnt - aw0, re_cnt - re0, b_cnt - b0);
        end
        checks++;
        if (fe_cnt - fe0 != 0) begin
            errors++;
            $display("FAIL drop_no_frame_end: got %0d required 0", fe_cnt - fe0);
        end
        checks++;
        if (dut.state !== IDLE || DMA_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle_state: got state %0d busy %b required %0d 0", dut.state, DMA_BUSY, IDLE);
        end
        CAPON = 1'b1;
        repeat (2) @(negedge ACLK);
    endtask

    task automatic test_err_revsync();
        snap();
        err_b_abs = b0 + 1;
        vsync_pulse();
        wait_on(0, aw0 + 3, 300, "err_reach_burst3");
        vsync_pulse();
        wait_on(2, fe0 + 1, 400, "err_frame_end");
        err_b_abs = -1;
        checks++;
        if (err_cnt - err0 != 1) begin
            errors++;
            $display("FAIL err_pulse: got %0d cycles required 1", err_cnt - err0);
        end
        checks++;
        if (aw_cnt - aw0 != 4 || b_cnt - b0 != 4) begin
            errors++;
            $display("FAIL err_frame_complete: got aw %0d resp %0d required 4 4", aw_cnt - aw0, b_cnt - b0);
        end
        repeat (30) @(negedge ACLK);
        checks++;
        if (aw_cnt - aw0 != 4 || DMA_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL revsync_ignored: got aw %0d busy %b required 4 0", aw_cnt - aw0, DMA_BUSY);
        end
        vsync_pulse();
        wait_on(2, fe0 + 2, 600, "revsync_frame_end");
        checks++;
        if (aw_cnt - aw0 != 8 || err_cnt - err0 != 1) begin
            errors++;
            $display("FAIL revsync_next_frame: got aw %0d errs %0d required 8 1", aw_cnt - aw0, err_cnt - err0);
        end
    endtask

    task automatic test_reset_mid();
        snap();
        vsync_pulse();
        wait_on(1, w0 + 5, 300, "rstmid_reach_data");
        ARESETN = 1'b0;
        @(negedge ACLK);
        checks++;
        if ({AWVALID, WVALID, BREADY, FIFO_RE, DMA_BUSY} !== 5'b0) begin
            errors++;
            $display("FAIL rstmid_outputs: got %b required 00000", {AWVALID, WVALID, BREADY, FIFO_RE, DMA_BUSY});
        end
        checks++;
        if (dut.state !== IDLE) begin
            errors++;
            $display("FAIL rstmid_state: got %0d required %0d", dut.state, IDLE);
        end
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);
    endtask

    initial begin
        exp_addr[0] = 32'h0100_0040; exp_addr[1] = 32'h0100_0080;
        exp_addr[2] = 32'h0100_00C0; exp_addr[3] = 32'h0100_0100;
        exp_last[0] = 15; exp_last[1] = 31; exp_last[2] = 47; exp_last[3] = 63;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_starvation();
        test_capon_drop();
        test_err_revsync();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
